// File: rtl/fast_pkg.sv
// Types and widths shared by the FAST corner pipeline stages.
package fast_pkg;

  localparam int COORD_W = 11;
  localparam int SCORE_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SCORE_W-1:0] score;
  } corner_rec_t;

endpackage

// File: rtl/corner_xy_extract_fifo.sv
// Show-ahead corner record FIFO with a registered read port.
// The head entry stays in storage until popped, so the total capacity is DEPTH.
module corner_fifo
  import fast_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  corner_rec_t              i_wdata,
  input  logic                     i_ready,
  output logic                     o_valid,
  output corner_rec_t              o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  corner_rec_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  corner_rec_t   r_rdata;
  logic          r_valid;

  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_cnt_after_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_valid = r_valid;
  assign o_rdata = r_rdata;

  // A write into a full FIFO is legal only when the head leaves on the same edge.
  assign w_pop           = r_valid & i_ready;
  assign w_push          = i_push & (!o_full | w_pop);
  assign w_rd_ptr_nxt    = r_rd_ptr + AW'(w_pop);
  assign w_cnt_after_pop = r_cnt - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Read stage: entries written this edge become visible one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_cnt    <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_valid  <= (w_cnt_after_pop != '0);
      r_rdata  <= r_mem[w_rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/corner_xy_extract.sv
// Tags surviving NMS scores with their raster position and queues {x, y, score}
// records for the downstream readout, with per-frame cap and loss flags.
module corner_xy_extract
  import fast_pkg::*;
#(
  parameter int SCORE_MIN   = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_CORNERS = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_H_SYNC,
  input  logic               in_V_SYNC,
  input  logic               in_data_en,
  input  logic [SCORE_W-1:0] score,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  logic               TVALID_in,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_frame_done,
  output logic [COORD_W-1:0] o_corner_cnt,
  output logic               o_overflow,
  output logic               o_limit
);

  logic               r_vs_prev;
  logic               r_armed;
  logic               r_done;
  logic               r_frame_done;
  logic               r_overflow;
  logic               r_limit;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COORD_W-1:0] r_cnt;

  logic               w_fs;
  logic               w_acc;
  logic               w_cand;
  logic               w_cap;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic               w_valid;
  logic               w_last_col;
  logic               w_last_row;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic [COORD_W-1:0] w_cnt;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_cnt;
  corner_rec_t        w_rec;
  corner_rec_t        w_rdata;
  logic               w_unused;

  // A pixel on the frame-start cycle already sits at (0,0) with cleared counts.
  assign w_fs       = TVALID_in & in_V_SYNC & !r_vs_prev;
  assign w_x        = w_fs ? '0 : r_x;
  assign w_y        = w_fs ? '0 : r_y;
  assign w_cnt      = w_fs ? '0 : r_cnt;
  assign w_acc      = TVALID_in & in_V_SYNC & in_data_en & (r_armed | w_fs) & (w_fs | !r_done);
  assign w_last_col = (w_x == width - COORD_W'(1));
  assign w_last_row = (w_y == height - COORD_W'(1));
  assign w_cand     = w_acc & (score >= SCORE_W'(SCORE_MIN)) & (score != '0);
  assign w_cap      = (w_cnt == COORD_W'(MAX_CORNERS));
  assign w_pop      = w_valid & o_ready;
  assign w_push     = w_cand & !w_cap & (!w_full | w_pop);
  assign w_rec      = '{x: w_x, y: w_y, score: score};
  assign w_unused   = ^{in_H_SYNC, w_empty, w_fifo_cnt};

  // Position / frame stage; r_vs_prev resets high so a frame already in flight is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev    <= 1'b1;
      r_armed      <= 1'b0;
      r_done       <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_cnt        <= '0;
      r_overflow   <= 1'b0;
      r_limit      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_acc & w_last_col & w_last_row;
      r_cnt        <= w_cnt + COORD_W'(w_push);
      r_overflow   <= (r_overflow & !w_fs) | (w_cand & !w_cap & w_full & !w_pop);
      r_limit      <= (r_limit & !w_fs) | (w_cand & w_cap);
      if (TVALID_in) begin
        r_vs_prev <= in_V_SYNC;
        if (w_fs) begin
          r_armed <= 1'b1;
          r_done  <= 1'b0;
        end
        if (!in_V_SYNC || w_fs) begin
          r_x <= '0;
          r_y <= '0;
        end
        if (w_acc) begin
          if (w_last_col) begin
            r_x <= '0;
            r_y <= w_last_row ? '0 : w_y + COORD_W'(1);
            if (w_last_row) r_done <= 1'b1;
          end else begin
            r_x <= w_x + COORD_W'(1);
          end
        end
      end
    end
  end

  corner_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_rec),
    .i_ready (o_ready),
    .o_valid (w_valid),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_cnt)
  );

  assign o_valid      = w_valid;
  assign o_x          = w_rdata.x;
  assign o_y          = w_rdata.y;
  assign o_score      = w_rdata.score;
  assign o_frame_done = r_frame_done;
  assign o_corner_cnt = r_cnt;
  assign o_overflow   = r_overflow;
  assign o_limit      = r_limit;

endmodule

// File: tb/tb_corner_xy_extract.sv
// Bench for corner_xy_extract: three parameterisations share one stimulus stream
// and are compared against a raster-scan reference list per frame.
module tb_corner_xy_extract;

  localparam int ND  = 3;
  localparam int BIG = 1 << 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs = 1'b0, vs = 1'b0, de = 1'b0, tv = 1'b0, rdy = 1'b0;
  logic [7:0]  sc = '0;
  logic [10:0] wd = 11'd1, ht = 11'd1;

  logic        vld [ND];
  logic [10:0] ox [ND], oy [ND], ocnt [ND];
  logic [7:0]  osc [ND];
  logic        fd [ND], ovf [ND], lim [ND];

  always #5 clk = ~clk;

  corner_xy_extract #(.SCORE_MIN(1), .FIFO_DEPTH(16), .MAX_CORNERS(1023)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_H_SYNC(hs), .in_V_SYNC(vs), .in_data_en(de), .score(sc),
    .width(wd), .height(ht), .TVALID_in(tv), .o_valid(vld[0]), .o_ready(rdy), .o_x(ox[0]),
    .o_y(oy[0]), .o_score(osc[0]), .o_frame_done(fd[0]), .o_corner_cnt(ocnt[0]),
    .o_overflow(ovf[0]), .o_limit(lim[0]));

  corner_xy_extract #(.SCORE_MIN(100), .FIFO_DEPTH(16), .MAX_CORNERS(1023)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_H_SYNC(hs), .in_V_SYNC(vs), .in_data_en(de), .score(sc),
    .width(wd), .height(ht), .TVALID_in(tv), .o_valid(vld[1]), .o_ready(rdy), .o_x(ox[1]),
    .o_y(oy[1]), .o_score(osc[1]), .o_frame_done(fd[1]), .o_corner_cnt(ocnt[1]),
    .o_overflow(ovf[1]), .o_limit(lim[1]));

  corner_xy_extract #(.SCORE_MIN(1), .FIFO_DEPTH(16), .MAX_CORNERS(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_H_SYNC(hs), .in_V_SYNC(vs), .in_data_en(de), .score(sc),
    .width(wd), .height(ht), .TVALID_in(tv), .o_valid(vld[2]), .o_ready(rdy), .o_x(ox[2]),
    .o_y(oy[2]), .o_score(osc[2]), .o_frame_done(fd[2]), .o_corner_cnt(ocnt[2]),
    .o_overflow(ovf[2]), .o_limit(lim[2]));

  function automatic int p_min(input int k);
    return (k == 1) ? 100 : 1;
  endfunction

  function automatic int p_max(input int k);
    return (k == 2) ? 3 : 1023;
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  logic [29:0] exp_q [ND][$];
  logic [7:0]  pix [$];
  int          e_cnt [ND];
  logic        e_ovf [ND], e_lim [ND];
  int          fd_cnt [ND];
  logic        hold [ND];
  logic [29:0] hold_rec [ND];

  // Output monitor: pops against the reference list and back-pressure stability.
  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      if (!rst_n) begin
        hold[k] = 1'b0;
      end else begin
        if (hold[k]) begin
          chk_eq($sformatf("d%0d_hold_vld", k), 32'(vld[k]), 32'd1);
          chk_eq($sformatf("d%0d_hold_rec", k), 32'({ox[k], oy[k], osc[k]}), 32'(hold_rec[k]));
        end
        if (fd[k]) fd_cnt[k]++;
        if (vld[k] && rdy) begin
          chk_eq($sformatf("d%0d_rec_avail", k), 32'(exp_q[k].size() != 0), 32'd1);
          if (exp_q[k].size() != 0)
            chk_eq($sformatf("d%0d_rec", k), 32'({ox[k], oy[k], osc[k]}), 32'(exp_q[k].pop_front()));
        end
        hold[k]     = vld[k] && !rdy;
        hold_rec[k] = {ox[k], oy[k], osc[k]};
      end
    end
  end

  // Reference: raster-order candidates, cut at the cap, then at the free room.
  task automatic build_exp(input int w, input int h, input int room);
    for (int k = 0; k < ND; k++) begin
      int n = 0;
      int kept = 0;
      for (int i = 0; i < w * h; i++) begin
        if (pix[i] != 0 && int'(pix[i]) >= p_min(k)) begin
          n++;
          if (kept < p_max(k) && kept < room) begin
            exp_q[k].push_back({11'(i % w), 11'(i / w), pix[i]});
            kept++;
          end
        end
      end
      e_cnt[k] = kept;
      e_lim[k] = (n > p_max(k)) && (p_max(k) <= room);
      e_ovf[k] = (((n > p_max(k)) ? p_max(k) : n) > room);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pending();
    int p = 0;
    for (int k = 0; k < ND; k++) p += exp_q[k].size() + int'(vld[k]);
    return p;
  endfunction

  task automatic fill_pix(input int n, input logic [7:0] val);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(val);
  endtask

  task automatic gen_pix(input int n, input int dens);
    int nz = 0;
    pix.delete();
    for (int i = 0; i < n; i++) begin
      if (nz < 16 && $urandom_range(0, 99) < dens) begin
        pix.push_back(8'($urandom_range(1, 255)));
        nz++;
      end else begin
        pix.push_back(8'd0);
      end
    end
  endtask

  // rmode: 0 ready low, 1 ready high, 2 random, 3 low until the 17th pixel.
  task automatic run_frame(input int w, input int h, input int gate, input int rmode,
                           input int room, input int do_drain);
    int idx, cyc, total, budget;
    build_exp(w, h, room);
    wd = 11'(w);
    ht = 11'(h);
    vs = 1'b0; de = 1'b0; tv = 1'b1;
    rdy = (rmode == 1) ? 1'b1 : 1'b0;
    repeat (2) step();
    vs = 1'b1;
    step();
    for (int k = 0; k < ND; k++) begin
      fd_cnt[k] = 0;
      chk_eq($sformatf("d%0d_fs_cnt", k), 32'(ocnt[k]), 32'd0);
      chk_eq($sformatf("d%0d_fs_ovf", k), 32'(ovf[k]), 32'd0);
      chk_eq($sformatf("d%0d_fs_lim", k), 32'(lim[k]), 32'd0);
    end
    total  = w * h + 3;
    budget = total * 8 + 64;
    idx = 0;
    cyc = 0;
    while (idx < total && cyc < budget) begin
      tv = (gate != 0) ? 1'(cyc % 2) : 1'b1;
      de = (rmode == 0 || rmode == 3) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      sc = (idx < w * h) ? pix[idx] : 8'd250;
      hs = 1'(idx % w == 0);
      case (rmode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'(idx >= 16);
      endcase
      step();
      if (tv && de) idx++;
      cyc++;
    end
    chk_eq("pix_budget", 32'(idx), 32'(total));
    de = 1'b0;
    tv = 1'b1;
    repeat (2) step();
    for (int k = 0; k < ND; k++) begin
      chk_eq($sformatf("d%0d_cnt", k), 32'(ocnt[k]), 32'(e_cnt[k]));
      chk_eq($sformatf("d%0d_ovf", k), 32'(ovf[k]), 32'(e_ovf[k]));
      chk_eq($sformatf("d%0d_lim", k), 32'(lim[k]), 32'(e_lim[k]));
      chk_eq($sformatf("d%0d_frame_done", k), 32'(fd_cnt[k]), 32'd1);
    end
    vs = 1'b0;
    if (do_drain != 0) begin
      cyc = 0;
      while (pending() != 0 && cyc < 2000) begin
        rdy = 1'($urandom_range(0, 1));
        step();
        cyc++;
      end
      chk_eq("drain_left", 32'(pending()), 32'd0);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int k = 0; k < ND; k++) begin
      chk_eq($sformatf("d%0d_%s_vld", k, tag), 32'(vld[k]), 32'd0);
      chk_eq($sformatf("d%0d_%s_rec", k, tag), 32'({ox[k], oy[k], osc[k]}), 32'd0);
      chk_eq($sformatf("d%0d_%s_fd", k, tag), 32'(fd[k]), 32'd0);
      chk_eq($sformatf("d%0d_%s_cnt", k, tag), 32'(ocnt[k]), 32'd0);
      chk_eq($sformatf("d%0d_%s_ovf", k, tag), 32'(ovf[k]), 32'd0);
      chk_eq($sformatf("d%0d_%s_lim", k, tag), 32'(lim[k]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("rst");
    rst_n = 1'b1;
    step();

    // Two sparse corners in an 8x4 frame.
    fill_pix(32, 8'd0);
    pix[1 * 8 + 3] = 8'd200;
    pix[3 * 8 + 7] = 8'd50;
    run_frame(8, 4, 0, 1, BIG, 1);

    // Back-pressure: 32 candidates into a 16-deep buffer.
    fill_pix(32, 8'd9);
    run_frame(32, 1, 0, 0, 16, 1);

    // Full buffer with a pop on the same edge as the 17th candidate.
    fill_pix(17, 8'd9);
    run_frame(17, 1, 0, 3, BIG, 1);

    // TVALID toggling every cycle.
    gen_pix(8, 60);
    run_frame(4, 2, 1, 1, BIG, 1);

    // Five candidates against a cap of three.
    fill_pix(8, 8'd0);
    pix[1] = 8'd5; pix[3] = 8'd6; pix[4] = 8'd7; pix[5] = 8'd150; pix[6] = 8'd9;
    run_frame(8, 1, 0, 2, BIG, 1);

    repeat (6) begin
      w = $urandom_range(1, 12);
      h = $urandom_range(1, 6);
      gen_pix(w * h, 30);
      run_frame(w, h, $urandom_range(0, 1), 2, BIG, 1);
    end

    // Reset while records are still draining.
    fill_pix(16, 8'd120);
    run_frame(8, 2, 0, 0, 16, 0);
    rdy = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      chk_eq($sformatf("d%0d_rst_mid_vld", k), 32'(vld[k]), 32'd0);
      exp_q[k].delete();
    end
    step();
    chk_reset_state("rst_mid");
    rst_n = 1'b1;
    step();

    gen_pix(8, 50);
    run_frame(4, 2, 0, 2, BIG, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
